// File: rtl/pulse_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : pulse_sequencer
//  Purpose  : Plays a table of (period_ms, duration_ms) steps into the
//             period input of the ms-based pulse generator, optionally looping.
//  Revision : 1.0  initial release
// ============================================================================
module pulse_sequencer #(
    parameter int CNT_MAX = 100_000,
    parameter int DEPTH   = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [15:0]              wr_period,
    input  logic [15:0]              wr_dur,
    input  logic [$clog2(DEPTH):0]   num_steps,
    input  logic                     loop,
    input  logic                     start,
    input  logic                     stop,
    output logic [15:0]              period_ms,
    output logic [$clog2(DEPTH)-1:0] step_idx,
    output logic                     busy,
    output logic                     done
);

    localparam int                c_AW        = $clog2(DEPTH);
    localparam logic [c_AW:0]     c_DEPTH_N   = (c_AW+1)'(DEPTH);
    localparam logic [31:0]       c_TICK_LAST = 32'(CNT_MAX - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t          r_state,      w_state_nxt;
    logic [c_AW-1:0] r_idx,        w_idx_nxt;
    logic [c_AW:0]   r_steps,      w_steps_nxt;
    logic [15:0]     r_cur_period, w_cur_period_nxt;
    logic [15:0]     r_cur_dur,    w_cur_dur_nxt;
    logic [31:0]     r_tick,       w_tick_nxt;
    logic [31:0]     r_ms,         w_ms_nxt;
    logic [15:0]     r_period,     w_period_nxt;
    logic [c_AW-1:0] r_step_idx,   w_step_idx_nxt;

    logic [15:0]     r_tab_period [DEPTH];
    logic [15:0]     r_tab_dur    [DEPTH];

    logic [31:0]     w_dur_m1;
    logic            w_tick_wrap;
    logic            w_step_end;
    logic            w_last_step;

    // Step table; writes are allowed while running, a step only sees them at its LOAD.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_tab_period[i] <= '0;
                r_tab_dur[i]    <= '0;
            end
        end else if (wr_en) begin
            r_tab_period[wr_addr] <= wr_period;
            r_tab_dur[wr_addr]    <= wr_dur;
        end
    end

    assign w_dur_m1    = {16'd0, r_cur_dur} - 32'd1;
    assign w_tick_wrap = (r_tick == c_TICK_LAST);
    assign w_step_end  = w_tick_wrap && (r_ms == w_dur_m1);
    assign w_last_step = ({1'b0, r_idx} == (r_steps - 1'b1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_idx        <= '0;
            r_steps      <= '0;
            r_cur_period <= '0;
            r_cur_dur    <= '0;
            r_tick       <= '0;
            r_ms         <= '0;
            r_period     <= '0;
            r_step_idx   <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_idx        <= w_idx_nxt;
            r_steps      <= w_steps_nxt;
            r_cur_period <= w_cur_period_nxt;
            r_cur_dur    <= w_cur_dur_nxt;
            r_tick       <= w_tick_nxt;
            r_ms         <= w_ms_nxt;
            r_period     <= w_period_nxt;
            r_step_idx   <= w_step_idx_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_idx_nxt        = r_idx;
        w_steps_nxt      = r_steps;
        w_cur_period_nxt = r_cur_period;
        w_cur_dur_nxt    = r_cur_dur;
        w_tick_nxt       = r_tick;
        w_ms_nxt         = r_ms;
        w_period_nxt     = r_period;
        w_step_idx_nxt   = r_step_idx;

        if (stop) begin
            // Abort outranks start and any step end in the same cycle.
            w_state_nxt    = S_IDLE;
            w_idx_nxt      = '0;
            w_step_idx_nxt = '0;
            w_period_nxt   = '0;
            w_tick_nxt     = '0;
            w_ms_nxt       = '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_period_nxt = '0;
                    if (start && (num_steps != '0)) begin
                        w_steps_nxt    = (num_steps > c_DEPTH_N) ? c_DEPTH_N : num_steps;
                        w_idx_nxt      = '0;
                        w_step_idx_nxt = '0;
                        w_state_nxt    = S_LOAD;
                    end
                end
                S_LOAD: begin
                    w_cur_period_nxt = r_tab_period[r_idx];
                    w_cur_dur_nxt    = (r_tab_dur[r_idx] == 16'd0) ? 16'd1 : r_tab_dur[r_idx];
                    w_tick_nxt       = '0;
                    w_ms_nxt         = '0;
                    w_period_nxt     = r_tab_period[r_idx];
                    w_state_nxt      = S_RUN;
                end
                S_RUN: begin
                    if (w_tick_wrap) begin
                        w_tick_nxt = '0;
                        if (w_step_end) begin
                            // period_ms is left alone here so it holds through LOAD.
                            if (!w_last_step) begin
                                w_idx_nxt      = r_idx + 1'b1;
                                w_step_idx_nxt = r_idx + 1'b1;
                                w_state_nxt    = S_LOAD;
                            end else if (loop) begin
                                w_idx_nxt      = '0;
                                w_step_idx_nxt = '0;
                                w_state_nxt    = S_LOAD;
                            end else begin
                                w_period_nxt = '0;
                                w_state_nxt  = S_DONE;
                            end
                        end else begin
                            w_ms_nxt = r_ms + 32'd1;
                        end
                    end else begin
                        w_tick_nxt = r_tick + 32'd1;
                    end
                end
                S_DONE: begin
                    w_period_nxt   = '0;
                    w_idx_nxt      = '0;
                    w_step_idx_nxt = '0;
                    w_state_nxt    = S_IDLE;
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

    assign period_ms = r_period;
    assign step_idx  = r_step_idx;
    assign busy      = (r_state == S_LOAD) || (r_state == S_RUN);
    assign done      = (r_state == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_pulse_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pulse_sequencer
//  Purpose  : Directed, table-driven bench for pulse_sequencer (CNT_MAX=4).
//  Revision : 1.0  initial release
// ============================================================================
module tb_pulse_sequencer;

    localparam int CNT_MAX = 4;
    localparam int DEPTH   = 8;

    logic        clk;
    logic        reset;
    logic        wr_en;
    logic [2:0]  wr_addr;
    logic [15:0] wr_period;
    logic [15:0] wr_dur;
    logic [3:0]  num_steps;
    logic        loop;
    logic        start;
    logic        stop;
    logic [15:0] period_ms;
    logic [2:0]  step_idx;
    logic        busy;
    logic        done;

    int checks   = 0;
    int failures = 0;
    int done_seen;

    typedef struct {
        logic        start;
        logic [15:0] period;
        logic [2:0]  idx;
        logic        idx_care;
        logic        busy;
        logic        done;
    } vec_t;

    vec_t vecs [16];

    pulse_sequencer #(.CNT_MAX(CNT_MAX), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_period (wr_period),
        .wr_dur    (wr_dur),
        .num_steps (num_steps),
        .loop      (loop),
        .start     (start),
        .stop      (stop),
        .period_ms (period_ms),
        .step_idx  (step_idx),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_entry(input logic [2:0] a, input logic [15:0] p, input logic [15:0] d);
        wr_en = 1'b1; wr_addr = a; wr_period = p; wr_dur = d;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic kick();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    function automatic vec_t mk(input logic s, input logic [15:0] p, input logic [2:0] i,
                                input logic ic, input logic b, input logic d);
        vec_t v;
        v.start = s; v.period = p; v.idx = i; v.idx_care = ic; v.busy = b; v.done = d;
        return v;
    endfunction

    initial begin
        reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_period = '0; wr_dur = '0;
        num_steps = '0; loop = 1'b0; start = 1'b0; stop = 1'b0;
        tick();
        chk("rst_period", 32'(period_ms), 0);
        chk("rst_idx",    32'(step_idx),  0);
        chk("rst_busy",   32'(busy),      0);
        chk("rst_done",   32'(done),      0);
        reset = 1'b0;
        tick();

        // Test 1: two-step one-shot, cycle by cycle
        write_entry(3'd0, 16'd10, 16'd2);
        write_entry(3'd1, 16'd0,  16'd1);
        num_steps = 4'd2;
        vecs[0] = mk(1'b1, 16'd0, 3'd0, 1'b1, 1'b1, 1'b0);
        for (int k = 1; k <= 8; k++) vecs[k] = mk(1'b0, 16'd10, 3'd0, 1'b1, 1'b1, 1'b0);
        vecs[9] = mk(1'b0, 16'd10, 3'd1, 1'b1, 1'b1, 1'b0);
        for (int k = 10; k <= 13; k++) vecs[k] = mk(1'b0, 16'd0, 3'd1, 1'b1, 1'b1, 1'b0);
        vecs[14] = mk(1'b0, 16'd0, 3'd0, 1'b0, 1'b0, 1'b1);
        vecs[15] = mk(1'b0, 16'd0, 3'd0, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 16; k++) begin
            start = vecs[k].start;
            tick();
            chk($sformatf("t1_period[%0d]", k), 32'(period_ms), 32'(vecs[k].period));
            chk($sformatf("t1_busy[%0d]", k),   32'(busy),      32'(vecs[k].busy));
            chk($sformatf("t1_done[%0d]", k),   32'(done),      32'(vecs[k].done));
            if (vecs[k].idx_care)
                chk($sformatf("t1_idx[%0d]", k), 32'(step_idx), 32'(vecs[k].idx));
        end
        start = 1'b0;

        // Test 2: looping, three passes of 14 cycles each, then stop
        loop = 1'b1;
        done_seen = 0;
        kick();
        for (int t = 0; t < 42; t++) begin
            if (done) done_seen++;
            if (t % 14 == 1) begin
                chk($sformatf("t2_idx0[%0d]", t), 32'(step_idx), 0);
                chk($sformatf("t2_per0[%0d]", t), 32'(period_ms), 10);
            end
            if (t % 14 == 10) begin
                chk($sformatf("t2_idx1[%0d]", t), 32'(step_idx), 1);
                chk($sformatf("t2_per1[%0d]", t), 32'(period_ms), 0);
            end
            tick();
        end
        tick();
        chk("t2_pass4_per", 32'(period_ms), 10);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("t2_stop_per",  32'(period_ms), 0);
        chk("t2_stop_busy", 32'(busy),      0);
        chk("t2_stop_idx",  32'(step_idx),  0);
        chk("t2_stop_done", 32'(done),      0);
        chk("t2_no_done",   32'(done_seen), 0);
        tick();
        chk("t2_after_done", 32'(done), 0);
        loop = 1'b0;

        // Test 3: stop coincident with step end; start+stop in IDLE
        kick();
        repeat (8) tick();
        chk("t3_last_run", 32'(busy), 1);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("t3_stop_busy", 32'(busy),      0);
        chk("t3_stop_per",  32'(period_ms), 0);
        chk("t3_stop_done", 32'(done),      0);
        tick();
        chk("t3_no_load",   32'(busy), 0);
        chk("t3_no_done",   32'(done), 0);
        start = 1'b1; stop = 1'b1;
        tick();
        start = 1'b0; stop = 1'b0;
        chk("t3_ss_busy", 32'(busy),      0);
        chk("t3_ss_per",  32'(period_ms), 0);
        tick();
        chk("t3_ss_busy2", 32'(busy), 0);

        // Test 4a: zero duration lasts one ms
        write_entry(3'd0, 16'd7, 16'd0);
        num_steps = 4'd1;
        kick();
        tick();
        chk("t4_d0_first", 32'(period_ms), 7);
        repeat (3) tick();
        chk("t4_d0_last",  32'(period_ms), 7);
        chk("t4_d0_busy",  32'(busy),      1);
        tick();
        chk("t4_d0_done",  32'(done),      1);
        chk("t4_d0_per",   32'(period_ms), 0);
        tick();

        // Test 4b: zero steps is a no-op
        num_steps = 4'd0;
        kick();
        chk("t4_ns0_busy", 32'(busy), 0);
        tick();
        chk("t4_ns0_busy2", 32'(busy), 0);
        chk("t4_ns0_done",  32'(done), 0);

        // Test 4c: num_steps above DEPTH clamps to DEPTH
        for (int i = 0; i < DEPTH; i++) write_entry(3'(i), 16'(100 + i), 16'd1);
        num_steps = 4'd15;
        kick();
        for (int t = 0; t <= 40; t++) begin
            if ((t % 5 == 1) && (t < 40)) begin
                chk($sformatf("t4_cl_per[%0d]", t), 32'(period_ms), 32'(100 + t / 5));
                chk($sformatf("t4_cl_idx[%0d]", t), 32'(step_idx),  32'(t / 5));
            end
            if (t == 39) chk("t4_cl_busy39", 32'(busy), 1);
            if (t == 40) chk("t4_cl_done40", 32'(done), 1);
            if (t < 40) tick();
        end
        tick();
        chk("t4_cl_idle", 32'(busy), 0);

        // Test 5: table rewrites during a sequence
        write_entry(3'd0, 16'd10, 16'd2);
        write_entry(3'd1, 16'd0,  16'd1);
        num_steps = 4'd2;
        kick();
        for (int t = 0; t < 24; t++) begin
            if (t == 9)  chk("t5_load_hold", 32'(period_ms), 10);
            if (t == 10) chk("t5_new_per",   32'(period_ms), 25);
            if (t == 10) chk("t5_new_idx",   32'(step_idx),  1);
            if (t == 16) chk("t5_keep_per",  32'(period_ms), 25);
            if (t == 21) chk("t5_end_per",   32'(period_ms), 25);
            if (t == 21) chk("t5_end_busy",  32'(busy),      1);
            if (t == 22) chk("t5_done",      32'(done),      1);
            wr_en = 1'b0;
            if (t == 3)  begin wr_en = 1'b1; wr_addr = 3'd1; wr_period = 16'd25; wr_dur = 16'd3; end
            if (t == 12) begin wr_en = 1'b1; wr_addr = 3'd1; wr_period = 16'd55; wr_dur = 16'd1; end
            tick();
        end
        wr_en = 1'b0;

        // Test 6: asynchronous reset mid-sequence, then replay from zeroed table
        kick();
        repeat (11) tick();
        chk("t6_pre_per", 32'(period_ms), 55);
        #1 reset = 1'b1;
        #1;
        chk("t6_rst_per",  32'(period_ms), 0);
        chk("t6_rst_idx",  32'(step_idx),  0);
        chk("t6_rst_busy", 32'(busy),      0);
        chk("t6_rst_done", 32'(done),      0);
        #1 reset = 1'b0;
        tick();
        kick();
        tick();
        chk("t6_re_busy", 32'(busy),      1);
        chk("t6_re_per0", 32'(period_ms), 0);
        chk("t6_re_idx0", 32'(step_idx),  0);
        repeat (5) tick();
        chk("t6_re_idx1", 32'(step_idx),  1);
        chk("t6_re_per1", 32'(period_ms), 0);
        repeat (4) tick();
        chk("t6_re_done", 32'(done), 1);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
